// File: rtl/cc_ctrl_seq.sv
// Command sequencer driving the cc decoder pi bus (setup/strobe/recover) with a response FIFO.
// Optional macro CC_SEQ_PARITY_EN drives odd data parity on pi_bus[13].
module cc_ctrl_seq #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic [20:0] pi_bus,
  input  logic [19:0] po_bus,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [19:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(RSP_DEPTH);
  localparam logic [7:0]  SETUP_C   = 8'(SETUP_CYC);
  localparam logic [7:0]  HOLD_C    = 8'(HOLD_CYC);
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [AW:0] FULL_C    = (AW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_ABORT = 2'b10, OP_RSVD = 2'b11} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [20:0]   mem_q [RSP_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic          full, push, pop;
  logic [20:0]   push_word;

  assign full      = (count_q == FULL_C);
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q][19:0] : '0;
  assign rsp_err   = rsp_valid ? mem_q[rd_ptr_q][20]   : 1'b0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = '0;
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = !full && !reset;
        if (cmd_valid && cmd_ready) begin
          op_d   = op_t'(cmd_op);
          data_d = cmd_data;
          if (op_t'(cmd_op) == OP_RSVD) begin
            push      = 1'b1;
            push_word = {1'b1, 20'h00000};
          end else begin
            state_d = S_SETUP;
            cnt_d   = 8'd1;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q >= SETUP_C) begin
          state_d = S_STROBE;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STROBE: begin
        // ABORT completes on the hold count alone; others need ack or hit the timeout
        if (op_q == OP_ABORT) begin
          push = (cnt_q >= HOLD_C);
        end else if (cnt_q >= HOLD_C && po_bus[9]) begin
          push = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          push         = 1'b1;
          push_word[20] = 1'b1;
        end
        if (push) begin
          push_word[19:0] = po_bus;
          state_d         = S_RECOVER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pi_bus = '0;
    if (state_q == S_SETUP || state_q == S_STROBE) begin
      pi_bus[7:0] = data_q;
      pi_bus[11]  = (op_q == OP_ABORT);
      pi_bus[15]  = (op_q == OP_READ);
`ifdef CC_SEQ_PARITY_EN
      pi_bus[13]  = ~^data_q;
`else
      pi_bus[13]  = 1'b0;
`endif
      if (state_q == S_STROBE) begin
        pi_bus[8]  = 1'b1;
        pi_bus[9]  = 1'b1;
        pi_bus[10] = 1'b1;
        pi_bus[12] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_WRITE;
      data_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_cc_ctrl_seq.sv
// Directed bench for cc_ctrl_seq at default parameters; expected values are hand-computed constants.
module tb_cc_ctrl_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [20:0] pi_bus;
  logic [19:0] po_bus;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  cc_ctrl_seq #(.SETUP_CYC(1), .HOLD_CYC(2), .TIMEOUT(15), .RSP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .pi_bus(pi_bus), .po_bus(po_bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // pi_bus[13] contribution for a given data byte in SETUP/STROBE
  function automatic logic [20:0] par13(input logic [7:0] d);
`ifdef CC_SEQ_PARITY_EN
    return (~^d) ? 21'h002000 : 21'h000000;
`else
    return 21'h000000;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [19:0] po);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready", {31'd0, cmd_ready}, 32'd1);
    po_bus    = po;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    po_bus = 20'h00000; rsp_ready = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_pi", {11'd0, pi_bus}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {12'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // WRITE 0xA5 with ack from the first strobe cycle
    issue(2'b00, 8'hA5, 20'h12345);
    check("wr_setup_pi", {11'd0, pi_bus}, {11'd0, 21'h0000A5 | par13(8'hA5)});
    check("wr_setup_busy", {31'd0, busy}, 32'd1);
    check("wr_setup_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("wr_strobe1_pi", {11'd0, pi_bus}, {11'd0, 21'h0017A5 | par13(8'hA5)});
    tick();
    check("wr_strobe2_pi", {11'd0, pi_bus}, {11'd0, 21'h0017A5 | par13(8'hA5)});
    check("wr_strobe2_nrsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("wr_recover_pi", {11'd0, pi_bus}, 32'd0);
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_data", {12'd0, rsp_data}, 32'h12345);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    check("wr_idle_busy", {31'd0, busy}, 32'd0);
    check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_popped", {31'd0, rsp_valid}, 32'd0);

    // READ 0x3C, ack never arrives: 15 strobe cycles then error
    issue(2'b01, 8'h3C, 20'hF0C0F);
    check("rd_setup_pi", {11'd0, pi_bus}, {11'd0, 21'h00803C | par13(8'h3C)});
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("rd_strobe%0d_pi", i), {11'd0, pi_bus}, {11'd0, 21'h00973C | par13(8'h3C)});
    end
    check("rd_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("rd_recover_pi", {11'd0, pi_bus}, 32'd0);
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_data", {12'd0, rsp_data}, 32'hF0C0F);
    check("rd_rsp_err", {31'd0, rsp_err}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // reserved opcode: immediate error entry, no bus activity
    issue(2'b11, 8'hFF, 20'h12345);
    check("rsv_pi", {11'd0, pi_bus}, 32'd0);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsv_rsp_data", {12'd0, rsp_data}, 32'd0);
    check("rsv_rsp_err", {31'd0, rsp_err}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsv_popped", {31'd0, rsp_valid}, 32'd0);

    // ABORT 0x55 ignores ack, completes ok after the hold count
    issue(2'b10, 8'h55, 20'h00ABC & 20'hFFDFF);
    check("ab_setup_pi", {11'd0, pi_bus}, {11'd0, 21'h000855 | par13(8'h55)});
    tick();
    check("ab_strobe1_pi", {11'd0, pi_bus}, {11'd0, 21'h001F55 | par13(8'h55)});
    tick();
    check("ab_strobe2_pi", {11'd0, pi_bus}, {11'd0, 21'h001F55 | par13(8'h55)});
    tick();
    check("ab_recover_pi", {11'd0, pi_bus}, 32'd0);
    check("ab_rsp_data", {12'd0, rsp_data}, 32'h008BC);
    check("ab_rsp_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // parity bit for 0x01 and 0x03
    issue(2'b00, 8'h01, 20'h00200);
    check("par01_bit13", {31'd0, pi_bus[13]}, 32'd0);
    repeat (4) tick();
    issue(2'b00, 8'h03, 20'h00200);
`ifdef CC_SEQ_PARITY_EN
    check("par03_bit13", {31'd0, pi_bus[13]}, 32'd1);
`else
    check("par03_bit13", {31'd0, pi_bus[13]}, 32'd0);
`endif
    repeat (4) tick();
    rsp_ready = 1'b1;
    tick(); tick();
    rsp_ready = 1'b0;
    check("par_drained", {31'd0, rsp_valid}, 32'd0);

    // fill the FIFO with rsp_ready low, then backpressure and ordering
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 8'h10 + 8'(i), 20'h00200 | 20'(i));
      repeat (4) tick();
    end
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    po_bus = 20'h00204; cmd_op = 2'b00; cmd_data = 8'h14; cmd_valid = 1'b1;
    tick();
    check("full_not_accepted", {31'd0, busy}, 32'd0);
    check("full_head", {12'd0, rsp_data}, 32'h00200);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    check("fifth_accepted", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("fifth_full_again", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("order_%0d", k), {12'd0, rsp_data}, 32'h00200 + k);
      tick();
    end
    rsp_ready = 1'b0;
    check("order_drained", {31'd0, rsp_valid}, 32'd0);

    // reset pulsed during STROBE, with ack high so completion would otherwise occur
    issue(2'b00, 8'h77, 20'h00200);
    tick();
    check("rstmid_strobe_pi", {11'd0, pi_bus}, {11'd0, 21'h001777 | par13(8'h77)});
    reset = 1'b1;
    tick();
    check("rstmid_pi", {11'd0, pi_bus}, 32'd0);
    check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_ready", {31'd0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cc_ctrl_seq.md
# cc_ctrl_seq

Command sequencer that drives the 21-bit `pi` control bus of a cc-style control decoder and collects its 20-bit `po` response. Accepts opcode/data commands over a valid/ready interface, expands each into a setup → strobe → recover bus cycle, waits for the decoder's acknowledge with a timeout, and queues result words in a small response FIFO. It sits upstream of the decoder as its initiator.

## Interface
- `SETUP_CYC`, default 1: cycles data is driven with select low before the strobe (≥1).
- `HOLD_CYC`, default 2: minimum strobe cycles before acknowledge is honoured (≥1).
- `TIMEOUT`, default 15: maximum strobe cycles before error completion (> HOLD_CYC, ≤255).
- `RSP_DEPTH`, default 4: response FIFO entries (power of 2, ≥2).

- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_op`  in  2  00 WRITE, 01 READ, 10 ABORT, 11 reserved.
- `cmd_data`  in  8  data byte.
- `pi_bus`  out  21  bit n drives decoder input `pi<n>`.
- `po_bus`  in  20  bit n is decoder output `po<n>`.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  consumer pops head when high with `rsp_valid`.
- `rsp_data`  out  20  captured `po_bus`.
- `rsp_err`  out  1  head completed by timeout or reserved op.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `pi_bus` mapping: [7:0] data, [8] select A, [9] ack-enable, [10] select B, [11] abort, [12] enable, [13] parity (see Configuration), [14] mode (tied 0), [15] direction (1 = READ), [20:16] tied 0.
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- IDLE: `cmd_ready` = 1 iff FIFO not full. Accept → latch op/data, go SETUP (WRITE/READ/ABORT) or push error entry (reserved: `rsp_data`=0, `rsp_err`=1) and stay IDLE.
- SETUP: drive [7:0], [15]; [8],[9],[10],[12] low; [11] high for ABORT. Lasts SETUP_CYC cycles → STROBE.
- STROBE: additionally drive [8],[9],[10],[12] high. Counter starts at 1. Complete when counter ≥ HOLD_CYC and `po_bus[9]`=1 (ok), or counter = TIMEOUT (err). ABORT ignores acknowledge and always completes ok after exactly HOLD_CYC cycles.
- Completion cycle: capture `po_bus` into FIFO entry with err flag; go RECOVER.
- RECOVER: `pi_bus` = 0 for one cycle → IDLE.
- FIFO: push on completion, pop on `rsp_valid & rsp_ready`; simultaneous push/pop allowed at any occupancy including full. Bus cycle only starts when a slot is guaranteed, so push never overflows.
- Pointers wrap modulo RSP_DEPTH; count width log2(RSP_DEPTH)+1.

## Timing
- Reset values: `pi_bus`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, FIFO empty, FSM IDLE. `cmd_ready` may rise the cycle after `reset` deasserts.
- Accept at edge T: SETUP cycles T+1..T+SETUP_CYC; STROBE from T+SETUP_CYC+1.
- Ack sampled registered: completion on the edge where the condition holds; `rsp_valid` high the following cycle when FIFO was empty.
- Minimum command-to-command spacing: SETUP_CYC + HOLD_CYC + 2 cycles.
- `cmd_ready` low in SETUP/STROBE/RECOVER; `cmd_op`/`cmd_data` are don't-care when not accepted.
- Reset mid-operation: next cycle `pi_bus`=0, FSM IDLE, FIFO flushed; no response generated for the interrupted command.
- `rsp_data`/`rsp_err` stable while `rsp_valid` & !`rsp_ready`.

## Configuration
- `CC_SEQ_PARITY_EN` defined: `pi_bus[13]` = odd parity of latched data (XNOR-reduce of [7:0]) during SETUP and STROBE, 0 otherwise.
- Undefined: `pi_bus[13]` tied 0; no parity logic.

## Test plan
- WRITE 0xA5, ack high from first strobe cycle, defaults → SETUP 1 cycle, STROBE 2 cycles, `pi_bus[7:0]`=0xA5, [15]=0, one response `rsp_err`=0, `rsp_data`=`po_bus` at completion.
- READ 0x3C, ack never asserted → STROBE exactly 15 cycles, response `rsp_err`=1, `pi_bus`=0 in RECOVER.
- cmd_op=11 → no bus activity, immediate error entry `rsp_data`=0, `rsp_err`=1.
- Five WRITEs with `rsp_ready`=0 → four responses queued, `cmd_ready`=0 after fourth; pop one → fifth accepted; order preserved.
- `reset` pulsed during STROBE → `pi_bus`=0, `rsp_valid`=0, `busy`=0 next cycle.
- With `CC_SEQ_PARITY_EN`, WRITE 0x01 → `pi_bus[13]`=0; WRITE 0x03 → 1; without macro, always 0.
